// File: rtl/psram_block_scheduler_if.sv
// Port bundle for psram_block_scheduler: requester handshakes, the monarch
// register-write bus to the PSRAM controller, and its completion strobe.
interface psram_block_scheduler_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_write;
   logic [NUM_REQ-1:0]    req_sd;
   logic [16*NUM_REQ-1:0] req_block;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ-1:0]    req_done;
   logic [NUM_REQ-1:0]    req_error;
   logic [7:0]            monarch_axi_tdata;
   logic [1:0]            monarch_axi_taddress;
   logic                  monarch_axi_tvalid;
   logic                  monarch_axi_tready;
   logic                  psram_done;
   logic                  busy;

   modport master (
      input  req_valid, req_write, req_sd, req_block,
      input  monarch_axi_tready, psram_done,
      output req_ready, req_done, req_error,
      output monarch_axi_tdata, monarch_axi_taddress, monarch_axi_tvalid,
      output busy
   );

   modport slave (
      output req_valid, req_write, req_sd, req_block,
      output monarch_axi_tready, psram_done,
      input  req_ready, req_done, req_error,
      input  monarch_axi_tdata, monarch_axi_taddress, monarch_axi_tvalid,
      input  busy
   );
endinterface

// File: rtl/psram_block_scheduler.sv
// Round-robin scheduler sharing the PSRAM block-transfer engine: programs the
// controller's registers, waits for completion or timeout, clears, cools down.
module psram_block_scheduler #(
   parameter int NUM_REQ         = 2,
   parameter int COOLDOWN_CYCLES = 10,
   parameter int TIMEOUT_CYCLES  = 65535
) (
   input  logic                    clk,
   input  logic                    reset,
   psram_block_scheduler_if.master bus
);
   localparam int IDX_W   = $clog2(NUM_REQ);
   localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int CD_W    = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
   localparam int CD_LAST = (COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0;

   typedef enum logic [2:0] {
      S_IDLE, S_WR_LO, S_WR_HI, S_WR_ID, S_WR_INSTR, S_WAIT_DONE, S_CLEAR, S_COOLDOWN
   } state_t;

   state_t             state, state_nx;
   logic [IDX_W-1:0]   rr_ptr, grant, grant_q;
   logic [IDX_W:0]     cand;
   logic               found, grab;
   logic               write_q, sd_q, err_q;
   logic [15:0]        block_q;
   logic [TO_W-1:0]    wait_cnt;
   logic [CD_W-1:0]    cool_cnt;
   logic [NUM_REQ-1:0] done_q, error_q;
   logic               timeout_hit;

   // Search upward from rr_ptr, wrapping, for the first pending requester.
   always_comb begin
      found = 1'b0;
      grant = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
         if (!found && bus.req_valid[cand[IDX_W-1:0]]) begin
            found = 1'b1;
            grant = cand[IDX_W-1:0];
         end
      end
   end

   assign timeout_hit = (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no latch is inferred.
      state_nx                 = state;
      grab                     = 1'b0;
      bus.monarch_axi_tvalid   = 1'b0;
      bus.monarch_axi_taddress = 2'b00;
      bus.monarch_axi_tdata    = 8'h00;
      case (state)
         // A completion pulse still pending blocks the grant so the three pulse
         // outputs stay mutually exclusive even with no cooldown.
         S_IDLE: begin
            if (found && !reset && done_q == '0 && error_q == '0) begin
               grab     = 1'b1;
               state_nx = S_WR_LO;
            end
         end
         S_WR_LO: begin
            bus.monarch_axi_tvalid   = 1'b1;
            bus.monarch_axi_taddress = 2'b01;
            bus.monarch_axi_tdata    = block_q[7:0];
            if (bus.monarch_axi_tready) state_nx = S_WR_HI;
         end
         S_WR_HI: begin
            bus.monarch_axi_tvalid   = 1'b1;
            bus.monarch_axi_taddress = 2'b10;
            bus.monarch_axi_tdata    = block_q[15:8];
            if (bus.monarch_axi_tready) state_nx = S_WR_ID;
         end
         S_WR_ID: begin
            bus.monarch_axi_tvalid   = 1'b1;
            bus.monarch_axi_taddress = 2'b11;
            bus.monarch_axi_tdata    = 8'(grant_q);
            if (bus.monarch_axi_tready) state_nx = S_WR_INSTR;
         end
         S_WR_INSTR: begin
            bus.monarch_axi_tvalid   = 1'b1;
            bus.monarch_axi_taddress = 2'b00;
            bus.monarch_axi_tdata    = {4'b0, ~write_q & sd_q, write_q & sd_q, write_q, ~write_q};
            if (bus.monarch_axi_tready) state_nx = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (bus.psram_done || timeout_hit) state_nx = S_CLEAR;
         end
         // The controller instruction is level-sensitive, so it must be zeroed.
         S_CLEAR: begin
            bus.monarch_axi_tvalid = 1'b1;
            if (bus.monarch_axi_tready)
               state_nx = (COOLDOWN_CYCLES == 0) ? S_IDLE : S_COOLDOWN;
         end
         S_COOLDOWN: begin
            if (cool_cnt == CD_W'(CD_LAST)) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = '0;
      if (grab) bus.req_ready[grant] = 1'b1;
   end

   assign bus.req_done  = done_q;
   assign bus.req_error = error_q;
   assign bus.busy      = (state != S_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         rr_ptr   <= '0;
         grant_q  <= '0;
         write_q  <= 1'b0;
         sd_q     <= 1'b0;
         block_q  <= '0;
         err_q    <= 1'b0;
         wait_cnt <= '0;
         cool_cnt <= '0;
         done_q   <= '0;
         error_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state   <= state_nx;
         done_q  <= '0;
         error_q <= '0;
         if (grab) begin
            grant_q <= grant;
            write_q <= bus.req_write[grant];
            sd_q    <= bus.req_sd[grant];
            block_q <= bus.req_block[16*int'(grant) +: 16];
            rr_ptr  <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
         end
         if (state == S_WAIT_DONE) begin
            wait_cnt <= wait_cnt + TO_W'(1);
            if (bus.psram_done || timeout_hit) err_q <= !bus.psram_done;
         end else begin
            wait_cnt <= '0;
         end
         if (state == S_COOLDOWN) cool_cnt <= cool_cnt + CD_W'(1);
         else                     cool_cnt <= '0;
         if (state == S_CLEAR && bus.monarch_axi_tready) begin
            if (err_q) error_q[grant_q] <= 1'b1;
            else       done_q[grant_q]  <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_psram_block_scheduler.sv
// Randomized scoreboard bench for psram_block_scheduler: a transaction-level
// model predicts grants, register beats, completion pulses and their timing.
module tb_psram_block_scheduler;
   localparam int N    = 3;
   localparam int COOL = 10;
   localparam int TMO  = 100;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   psram_block_scheduler_if #(.NUM_REQ(N)) bus ();

   psram_block_scheduler #(
      .NUM_REQ(N), .COOLDOWN_CYCLES(COOL), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   typedef struct {
      logic [1:0] addr;
      logic [7:0] data;
      int         start;
      bit         is_instr;
      bit         is_clear;
   } beat_t;

   beat_t exp_q[$];
   int    n_vec = 0, n_miss = 0;
   int    cyc = 0;
   int    m_rr, next_free, pulse_due, done_at, stray_at, beat_start, cur_g;
   int    wait_start, wait_end, completions = 0;
   bit    in_transfer, pend_err, prev_tvalid, prev_hs, prev_stall, stop_req = 1'b0;
   logic [1:0] prev_addr;
   logic [7:0] prev_data;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   function automatic int model_grant(input logic [N-1:0] v, input int rr);
      for (int k = 0; k < N; k++)
         if (v[(rr + k) % N]) return (rr + k) % N;
      return -1;
   endfunction

   function automatic logic [7:0] instr_code(input bit wr, input bit sd);
      case ({wr, sd})
         2'b00:   return 8'h01;
         2'b01:   return 8'h09;
         2'b10:   return 8'h02;
         default: return 8'h06;
      endcase
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_rr = 0; next_free = 0; pulse_due = -1; done_at = -1; stray_at = -1;
      wait_start = -1; wait_end = -1; beat_start = 0; cur_g = 0;
      in_transfer = 0; pend_err = 0; prev_tvalid = 0; prev_hs = 0; prev_stall = 0;
      prev_addr = '0; prev_data = '0;
   endtask

   task automatic monitor_step();
      logic [N-1:0] exp_rdy, exp_done, exp_err;
      logic [15:0]  blk;
      beat_t        b;
      bit           hs;
      int           g, d;

      if ((bus.req_ready | bus.req_done | bus.req_error) != '0)
         check("exclusive", 32'($countones({bus.req_ready, bus.req_done, bus.req_error})), 1);

      if (prev_stall)
         check("hold", 32'({bus.monarch_axi_tvalid, bus.monarch_axi_taddress, bus.monarch_axi_tdata}),
               32'({1'b1, prev_addr, prev_data}));

      exp_rdy = '0;
      g = -1;
      if (!in_transfer && cyc >= next_free) begin
         g = model_grant(bus.req_valid, m_rr);
         if (g >= 0) exp_rdy[g] = 1'b1;
      end
      if (exp_rdy != '0 || bus.req_ready != '0)
         check("grant", 32'(bus.req_ready), 32'(exp_rdy));
      if (g >= 0) begin
         m_rr        = (g + 1) % N;
         in_transfer = 1;
         cur_g       = g;
         blk         = bus.req_block[16*g +: 16];
         exp_q.push_back('{2'b01, blk[7:0], cyc + 1, 1'b0, 1'b0});
         exp_q.push_back('{2'b10, blk[15:8], -1, 1'b0, 1'b0});
         exp_q.push_back('{2'b11, 8'(g), -1, 1'b0, 1'b0});
         exp_q.push_back('{2'b00, instr_code(bus.req_write[g], bus.req_sd[g]), -1, 1'b1, 1'b0});
      end

      if (bus.monarch_axi_tvalid && (!prev_tvalid || prev_hs)) beat_start = cyc;
      hs = bus.monarch_axi_tvalid && bus.monarch_axi_tready;
      if (hs) begin
         check("beat_pending", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            check("beat", 32'({bus.monarch_axi_taddress, bus.monarch_axi_tdata}), 32'({b.addr, b.data}));
            if (b.start >= 0) check("beat_start", beat_start, b.start);
            if (b.is_instr) begin
               // done early, done on the very last wait cycle, or no done at all
               d = $urandom_range(0, 19);
               if (d < 12)      d = $urandom_range(1, TMO - 1);
               else if (d < 15) d = TMO;
               else             d = 0;
               wait_start = cyc + 1;
               if (d > 0) begin
                  done_at  = cyc + d;
                  wait_end = cyc + d;
                  pend_err = 0;
               end else begin
                  done_at  = -1;
                  wait_end = cyc + TMO;
                  pend_err = 1;
               end
               exp_q.push_back('{2'b00, 8'h00, wait_end + 1, 1'b0, 1'b1});
            end
            if (b.is_clear) begin
               in_transfer = 0;
               pulse_due   = cyc + 1;
               next_free   = cyc + COOL + 1;
            end
         end
      end

      exp_done = '0;
      exp_err  = '0;
      if (cyc == pulse_due) begin
         if (pend_err) exp_err[cur_g]  = 1'b1;
         else          exp_done[cur_g] = 1'b1;
         completions++;
         stray_at = cyc + $urandom_range(1, COOL - 1);
      end
      if ((exp_done | exp_err | bus.req_done | bus.req_error) != '0) begin
         check("done", 32'(bus.req_done), 32'(exp_done));
         check("error", 32'(bus.req_error), 32'(exp_err));
      end

      prev_tvalid = bus.monarch_axi_tvalid;
      prev_hs     = hs;
      prev_stall  = bus.monarch_axi_tvalid && !bus.monarch_axi_tready;
      prev_addr   = bus.monarch_axi_taddress;
      prev_data   = bus.monarch_axi_tdata;
   endtask

   always @(negedge clk) if (!reset) monitor_step();

   initial begin : req_driver
      logic [N-1:0] rdy;
      bus.req_valid = '0;
      bus.req_write = '0;
      bus.req_sd    = '0;
      bus.req_block = '0;
      bus.req_valid[0]       = 1'b1;
      bus.req_write[0]       = 1'b1;
      bus.req_block[15:0]    = 16'h1234;
      forever begin
         @(negedge clk);
         rdy = bus.req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (rdy[i]) begin
               bus.req_valid[i] = 1'b0;
            end else if (!bus.req_valid[i] && !stop_req && $urandom_range(0, 2) == 0) begin
               bus.req_valid[i]          = 1'b1;
               bus.req_write[i]          = 1'($urandom);
               bus.req_sd[i]             = 1'($urandom);
               bus.req_block[16*i +: 16] = 16'($urandom);
            end else if (bus.req_valid[i] && $urandom_range(0, 299) == 0) begin
               bus.req_valid[i] = 1'b0;
            end
         end
      end
   end

   initial begin : psram_driver
      bus.psram_done         = 1'b0;
      bus.monarch_axi_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.monarch_axi_tready = ($urandom_range(0, 3) != 0);
         bus.psram_done         = (cyc == done_at) || (cyc == stray_at);
      end
   end

   initial begin : main
      bit in_win;
      model_reset();
      reset = 1'b1;
      #1;
      check("rst_ready", 32'(bus.req_ready), 0);
      check("rst_done", 32'(bus.req_done | bus.req_error), 0);
      check("rst_tvalid", 32'(bus.monarch_axi_tvalid), 0);
      check("rst_busy", 32'(bus.busy), 0);
      repeat (3) @(posedge clk);
      #3 reset = 1'b0;

      for (int k = 0; k < 40000 && completions < 16; k++) @(posedge clk);

      in_win = 0;
      for (int k = 0; k < 4000 && !in_win; k++) begin
         @(posedge clk);
         #1;
         in_win = (wait_start >= 0 && cyc >= wait_start && cyc <= wait_end);
      end
      check("reached_wait", 32'(in_win), 1);
      #2 reset = 1'b1;
      model_reset();
      #1;
      check("midrst_ready", 32'(bus.req_ready), 0);
      check("midrst_done", 32'(bus.req_done | bus.req_error), 0);
      check("midrst_tvalid", 32'(bus.monarch_axi_tvalid), 0);
      check("midrst_busy", 32'(bus.busy), 0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;

      for (int k = 0; k < 40000 && completions < 32; k++) @(posedge clk);
      check("completions", 32'(completions >= 32), 1);

      stop_req = 1'b1;
      for (int k = 0; k < 5000 && (in_transfer || exp_q.size() != 0 || bus.req_valid != '0
                                   || cyc <= pulse_due); k++)
         @(posedge clk);
      repeat (2) @(posedge clk);
      check("drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
